// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the staggered reset sequencer.
// Imported by the sequencer top and any domain that reuses its widths.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD,
    STAGGER,
    DONE
  } state_e;

  localparam int SEQ_CNT_W = 8;

  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_gen_rst_sync.sv
// Async-assert, sync-deassert reset synchroniser.
// Reusable at the top of any clock domain.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  if (SYNC_STAGES < 2) begin : g_param_err
    $error("rst_sync: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = ff[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Multi-channel reset sequencer: channels assert together and
// release one by one, channel 0 first, with a software re-run.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sw_rst_req,
  output logic [NUM_CH-1:0]    ch_rst_n,
  output logic                 all_released,
  output logic                 busy,
  output logic [SEQ_CNT_W-1:0] seq_count
);

  if (NUM_CH < 1 || SYNC_STAGES < 2 ||
      HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_err
    $error("rst_seq_gen: parameter below minimum");
  end

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_CH  = IW'(NUM_CH - 1);
  localparam logic [SEQ_CNT_W-1:0] SEQ_MAX = '1;

  logic          rst_sync_n;
  state_e        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_sync_n(rst_sync_n)
  );

  // The cleared counter makes the edge where rst_sync_n rises
  // (or the request edge) count as sequence cycle zero.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      ch_rst_n     <= '0;
      all_released <= 1'b0;
      busy         <= 1'b1;
      seq_count    <= '0;
      state        <= HOLD;
      cnt          <= '0;
      idx          <= '0;
    end else if (sw_rst_req) begin
      ch_rst_n     <= '0;
      all_released <= 1'b0;
      busy         <= 1'b1;
      state        <= HOLD;
      cnt          <= '0;
      idx          <= '0;
    end else begin
      unique case (state)
        HOLD: begin
          if (cnt == HOLD_END) begin
            ch_rst_n <= (ch_rst_n << 1) | NUM_CH'(1);
            cnt      <= '0;
            if (NUM_CH == 1) begin
              state        <= DONE;
              all_released <= 1'b1;
              busy         <= 1'b0;
              if (seq_count != SEQ_MAX)
                seq_count <= seq_count + SEQ_CNT_W'(1);
            end else begin
              state <= STAGGER;
              idx   <= IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STAGGER: begin
          if (cnt == GAP_END) begin
            ch_rst_n <= (ch_rst_n << 1) | NUM_CH'(1);
            cnt      <= '0;
            if (idx == LAST_CH) begin
              state        <= DONE;
              all_released <= 1'b1;
              busy         <= 1'b0;
              if (seq_count != SEQ_MAX)
                seq_count <= seq_count + SEQ_CNT_W'(1);
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for the staggered reset sequencer.
// Times are counted in rising edges from each sequence start.
module tb_rst_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw = 1'b0;
  logic       sw1 = 1'b0;
  logic [3:0] ch;
  logic       all;
  logic       busy;
  logic [7:0] seq;
  logic [0:0] ch1;
  logic       all1;
  logic       busy1;
  logic [7:0] seq1;

  int checks = 0;
  int failures = 0;
  int t = 0;

  always #5 clk = ~clk;

  rst_seq_gen #(
    .NUM_CH(4), .SYNC_STAGES(2),
    .HOLD_CYCLES(16), .GAP_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw),
    .ch_rst_n(ch), .all_released(all),
    .busy(busy), .seq_count(seq)
  );

  rst_seq_gen #(
    .NUM_CH(1), .SYNC_STAGES(2),
    .HOLD_CYCLES(1), .GAP_CYCLES(4)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw1),
    .ch_rst_n(ch1), .all_released(all1),
    .busy(busy1), .seq_count(seq1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic to_edge(input int e);
    repeat (e - t) @(posedge clk);
    t = e;
    #1;
  endtask

  task automatic power_on();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    t = 0;
  endtask

  task automatic sw_pulse();
    sw = 1'b1;
    to_edge(t + 1);
    sw = 1'b0;
    t = 0;
  endtask

  task automatic run_seq(input string p, input int seq_exp);
    to_edge(15);
    check({p, "_ch_t15"}, ch, 4'b0000);
    check({p, "_busy_t15"}, busy, 1'b1);
    to_edge(16);
    check({p, "_ch_t16"}, ch, 4'b0001);
    to_edge(19);
    check({p, "_ch_t19"}, ch, 4'b0001);
    to_edge(20);
    check({p, "_ch_t20"}, ch, 4'b0011);
    to_edge(24);
    check({p, "_ch_t24"}, ch, 4'b0111);
    to_edge(27);
    check({p, "_ch_t27"}, ch, 4'b0111);
    check({p, "_all_t27"}, all, 1'b0);
    check({p, "_seq_t27"}, seq, seq_exp - 1);
    to_edge(28);
    check({p, "_ch_t28"}, ch, 4'b1111);
    check({p, "_all_t28"}, all, 1'b1);
    check({p, "_busy_t28"}, busy, 1'b0);
    check({p, "_seq_t28"}, seq, seq_exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ch", ch, 4'b0000);
    check("rst_all", all, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_seq", seq, 8'd0);

    power_on();
    check("por_ch_t0", ch, 4'b0000);
    check("n1_ch_t0", ch1, 1'b0);
    check("n1_all_t0", all1, 1'b0);
    to_edge(1);
    check("n1_ch_t1", ch1, 1'b1);
    check("n1_all_t1", all1, 1'b1);
    check("n1_busy_t1", busy1, 1'b0);
    check("n1_seq_t1", seq1, 8'd1);
    run_seq("por", 1);

    to_edge(40);
    check("done_idle_ch", ch, 4'b1111);
    sw_pulse();
    check("sw_ch_e", ch, 4'b0000);
    check("sw_all_e", all, 1'b0);
    check("sw_busy_e", busy, 1'b1);
    run_seq("sw", 2);

    sw_pulse();
    to_edge(22);
    check("mid_ch_t22", ch, 4'b0011);
    sw_pulse();
    check("mid_ch_e", ch, 4'b0000);
    check("mid_busy_e", busy, 1'b1);
    run_seq("mid", 3);

    sw = 1'b1;
    to_edge(t + 1);
    to_edge(t + 1);
    to_edge(t + 1);
    sw = 1'b0;
    t = 0;
    check("hold_ch_e", ch, 4'b0000);
    to_edge(15);
    check("hold_ch_t15", ch, 4'b0000);
    to_edge(16);
    check("hold_ch_t16", ch, 4'b0001);
    to_edge(28);
    check("hold_ch_t28", ch, 4'b1111);
    check("hold_seq_t28", seq, 8'd4);

    sw_pulse();
    to_edge(25);
    check("arst_ch_t25", ch, 4'b0111);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ch", ch, 4'b0000);
    check("arst_all", all, 1'b0);
    check("arst_busy", busy, 1'b1);
    check("arst_seq", seq, 8'd0);
    check("arst_n1_ch", ch1, 1'b0);
    power_on();
    run_seq("por2", 1);

    for (int i = 0; i < 260; i++) begin
      sw = 1'b1;
      @(posedge clk);
      #1 sw = 1'b0;
      repeat (28) @(posedge clk);
      #1;
    end
    check("sat_seq", seq, 8'd255);
    check("sat_all", all, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
